// File: rtl/dm_pkg.sv
// Shared types and helpers for the MEM-stage data-memory responder.
// Access-type codes, FSM states and byte-lane helpers.
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF   = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE   = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } dm_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } dm_size_t;

  // Reserved codes 101..111 fall through to word.
  function automatic dm_size_t dm_size(
    input logic [2:0] t
  );
    dm_size_t sz;
    sz = SZ_W;
    unique case (1'b1)
      (t == DM_BYTE),
      (t == DM_BYTE_U): sz = SZ_B;
      (t == DM_HALF),
      (t == DM_HALF_U): sz = SZ_H;
      default:          sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic dm_signed(
    input logic [2:0] t
  );
    return (t == DM_HALF) || (t == DM_BYTE);
  endfunction

  function automatic logic [1:0] dm_align(
    input dm_size_t   sz,
    input logic [1:0] off
  );
    logic [1:0] o;
    o = off;
    unique case (sz)
      SZ_B:    o = off;
      SZ_H:    o = {off[1], 1'b0};
      default: o = 2'b00;
    endcase
    return o;
  endfunction

  function automatic logic dm_misaligned(
    input dm_size_t   sz,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    unique case (sz)
      SZ_B:    m = 1'b0;
      SZ_H:    m = off[0];
      default: m = |off;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] dm_lane_sel(
    input dm_size_t   sz,
    input logic [1:0] off
  );
    logic [3:0] be;
    be = 4'b1111;
    unique case (sz)
      SZ_B:    be = 4'b0001 << off;
      SZ_H:    be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dm_sram_bank.sv
// Single-port word RAM, byte-lane write enables, registered read.
// Contents are never reset.
module dm_sram_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [3:0]       i_be,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    r_q <= r_mem[i_idx];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/mem_stage_dm.sv
// MEM-stage data-memory responder with wait states and pipeline stall.
// Optional misaligned-access trap: define DM_MISALIGN_TRAP_EN.
module mem_stage_dm
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_type,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        misalign_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  dm_state_t        r_state;
  logic [3:0]       r_cnt;
  logic             r_we;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_off;
  logic [31:0]      r_wdata;
  logic [2:0]       r_type;
  logic             r_rsp_valid;
  logic [31:0]      r_rdata;
  logic             r_err;

  dm_size_t         w_sz;
  logic [1:0]       w_off;
  logic             w_mis;
  logic             w_done;
  logic [3:0]       w_be;
  logic             w_ram_we;
  logic [IDX_W-1:0] w_ram_idx;
  logic [31:0]      w_ram_wd;
  logic [31:0]      w_ram_q;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic             w_sgn;
  logic [31:0]      w_load;
  logic             w_stall;
  logic             w_unused_addr;

  assign w_unused_addr = ^req_addr[31:IDX_W+2];

  assign w_sz   = dm_size(r_type);
  assign w_off  = dm_align(w_sz, r_off);
  assign w_be   = dm_lane_sel(w_sz, w_off);
  assign w_done = (r_state == S_BUSY)
               && (r_cnt == 4'd0);

`ifdef DM_MISALIGN_TRAP_EN
  assign w_mis = dm_misaligned(w_sz, r_off);
`else
  assign w_mis = 1'b0;
`endif

  // Gated by rstn so a reset before the commit edge drops the store.
  assign w_ram_we = rstn & w_done
                  & r_we & ~w_mis;

  // Read is issued from the live request in IDLE so data is
  // ready by the final BUSY edge even with zero wait states.
  assign w_ram_idx = (r_state == S_IDLE)
                   ? req_addr[IDX_W+1:2]
                   : r_idx;

  always_comb begin
    w_ram_wd = r_wdata;
    unique case (w_sz)
      SZ_B:    w_ram_wd = {4{r_wdata[7:0]}};
      SZ_H:    w_ram_wd = {2{r_wdata[15:0]}};
      default: w_ram_wd = r_wdata;
    endcase
  end

  dm_sram_bank #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_bank (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_be    (w_be),
    .i_idx   (w_ram_idx),
    .i_wdata (w_ram_wd),
    .o_rdata (w_ram_q)
  );

  always_comb begin
    w_byte = w_ram_q[8*w_off +: 8];
    w_half = w_off[1] ? w_ram_q[31:16]
                      : w_ram_q[15:0];
    w_sgn  = dm_signed(r_type);
    w_load = w_ram_q;
    unique case (w_sz)
      SZ_B:    w_load = {{24{w_sgn & w_byte[7]}},
                         w_byte};
      SZ_H:    w_load = {{16{w_sgn & w_half[15]}},
                         w_half};
      default: w_load = w_ram_q;
    endcase
  end

  always_comb begin
    w_stall = 1'b0;
    if (rstn) begin
      unique case (r_state)
        S_IDLE:  w_stall = req_valid;
        S_BUSY:  w_stall = 1'b1;
        default: w_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_idx       <= '0;
      r_off       <= 2'b00;
      r_wdata     <= 32'd0;
      r_type      <= DM_WORD;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_idx   <= req_addr[IDX_W+1:2];
            r_off   <= req_addr[1:0];
            r_wdata <= req_wdata;
            r_type  <= req_type;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rdata     <= (r_we | w_mis)
                         ? 32'd0 : w_load;
            r_rsp_valid <= 1'b1;
            r_err       <= w_mis;
            r_state     <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall        = w_stall;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rdata;
  assign misalign_err = r_err;

endmodule

// File: tb/tb_mem_stage_dm.sv
// Directed scoreboard bench for mem_stage_dm (WAIT_CYCLES=1).
// Expected responses are queued at issue and checked on rsp_valid.
module tb_mem_stage_dm;
  import dm_pkg::*;

  localparam int WAITC = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [2:0]  req_type = 3'd0;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misalign_err;

  int          n_tests = 0;
  int          n_fail = 0;
  int          n_rsp = 0;
  int          n0;
  logic [32:0] sb[$];
  logic [32:0] mon_e;

  always #5 clk = ~clk;

  mem_stage_dm #(
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_type     (req_type),
    .stall        (stall),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .misalign_err (misalign_err)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && rsp_valid) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp",
            {31'd0, rsp_valid}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e[31:0]);
        chk("rsp_err", {31'd0, misalign_err},
            {31'd0, mon_e[32]});
      end
    end
  end

  task automatic issue(
    input logic        we,
    input logic [31:0] addr,
    input logic [31:0] wd,
    input logic [2:0]  t,
    input logic [31:0] exp_rd,
    input logic        exp_err,
    input string       tag
  );
    int n;
    int g;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_type  = t;
    sb.push_back({exp_err, exp_rd});
    #1;
    n = 0;
    g = 0;
    do begin
      if (stall) n++;
      @(negedge clk);
      g++;
    end while (!rsp_valid && g < 40);
    chk({tag, "_rsp_seen"},
        {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_stall_len"}, 32'(n),
        32'(WAITC + 2));
    chk({tag, "_resp_stall"},
        {31'd0, stall}, 32'd0);
  endtask

  task automatic done(input string tag);
    req_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_end"},
        {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, misalign_err}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    req_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);

    issue(1, 32'h10, 32'hDEADBEEF, DM_WORD, 0, 0, "st_w");
    done("st_w");
    issue(0, 32'h10, 0, DM_WORD, 32'hDEADBEEF, 0, "ld_w");
    done("ld_w");
    issue(0, 32'h10, 0, 3'b111, 32'hDEADBEEF, 0, "ld_rsvd");
    done("ld_rsvd");

    issue(1, 32'h20, 32'h11223344, DM_WORD, 0, 0, "st_w20");
    done("st_w20");
    issue(1, 32'h21, 32'hAAAAAA80, DM_BYTE, 0, 0, "st_b");
    done("st_b");
    issue(0, 32'h21, 0, DM_BYTE, 32'hFFFFFF80, 0, "ld_b");
    done("ld_b");
    issue(0, 32'h21, 0, DM_BYTE_U, 32'h00000080, 0, "ld_bu");
    done("ld_bu");
    issue(0, 32'h20, 0, DM_WORD, 32'h11228044, 0, "ld_w20");
    done("ld_w20");

    issue(1, 32'h30, 32'h77776666, DM_WORD, 0, 0, "st_w30");
    done("st_w30");
    issue(1, 32'h32, 32'h55558001, DM_HALF, 0, 0, "st_h");
    done("st_h");
    issue(0, 32'h32, 0, DM_HALF, 32'hFFFF8001, 0, "ld_h");
    done("ld_h");
    issue(0, 32'h32, 0, DM_HALF_U, 32'h00008001, 0, "ld_hu");
    done("ld_hu");
    issue(0, 32'h30, 0, DM_WORD, 32'h80016666, 0, "ld_w30");
    done("ld_w30");

    issue(1, 32'h40, 32'hA5A5A5A5, DM_WORD, 0, 0, "st_w40");
    done("st_w40");
`ifdef DM_MISALIGN_TRAP_EN
    issue(1, 32'h41, 32'h12345678, DM_WORD, 0, 1, "st_mis");
    done("st_mis");
    issue(0, 32'h40, 0, DM_WORD, 32'hA5A5A5A5, 0, "ld_w40");
    done("ld_w40");
    issue(0, 32'h33, 0, DM_HALF, 32'h0, 1, "ld_mis_h");
    done("ld_mis_h");
`else
    issue(1, 32'h41, 32'h12345678, DM_WORD, 0, 0, "st_mis");
    done("st_mis");
    issue(0, 32'h40, 0, DM_WORD, 32'h12345678, 0, "ld_w40");
    done("ld_w40");
    issue(0, 32'h33, 0, DM_HALF, 32'hFFFF8001, 0, "ld_mis_h");
    done("ld_mis_h");
`endif

    issue(1, 32'h50, 32'hCAFEF00D, DM_WORD, 0, 0, "st_w50");
    done("st_w50");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h50;
    req_wdata = 32'h12345678;
    req_type  = DM_WORD;
    @(negedge clk);
    chk("busy_stall", {31'd0, stall}, 32'd1);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_busy_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy_rsp", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(0, 32'h50, 0, DM_WORD, 32'hCAFEF00D, 0, "ld_dropped");
    done("ld_dropped");

    issue(1, 32'h0, 32'h0BADF00D, DM_WORD, 0, 0, "st_w0");
    done("st_w0");
    n0 = n_rsp;
    issue(0, 32'h1010, 0, DM_WORD, 32'hDEADBEEF, 0, "b2b_a");
    issue(0, 32'h1000, 0, DM_WORD, 32'h0BADF00D, 0, "b2b_b");
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_pulses", 32'(n_rsp - n0), 32'd2);
    chk("rdata_hold", rsp_rdata, 32'h0BADF00D);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
